// File: rtl/stopwatch_pkg.sv
// Package: stopwatch_pkg
// Shared definitions for the stopwatch: the BCD digit type, the two digit
// range limits and a helper that maps a digit position to its maximum.
// Digit positions: 0 = tenths, 1 = seconds units, 2 = seconds tens,
// 3 and up = minutes.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIG_MAX_9 = 4'd9;
    localparam bcd_t DIG_MAX_5 = 4'd5;

    // Only the tens-of-seconds position is modulo 6; all others are decimal.
    function automatic bcd_t digit_max(input int idx);
        return (idx == 2) ? DIG_MAX_5 : DIG_MAX_9;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Module: bcd_digit_cell
// One BCD digit of the time counter with range 0..MAX. Steps up or down when
// enabled and reports a carry (wrapping MAX->0 upward) or a borrow (wrapping
// 0->MAX downward) so cells can be chained into a multi-digit counter.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   en          step this digit on the next edge
//   dir         0 = count up, 1 = count down
//   ld, ld_val  load a value, saturated to MAX
//   clr         synchronous clear to 0 (highest priority)
//   q           current digit value
//   carry_out   en, counting up and q at MAX
//   borrow_out  en, counting down and q at 0
module bcd_digit_cell
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = DIG_MAX_9
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic dir,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic clr,
    output bcd_t q,
    output logic carry_out,
    output logic borrow_out
);

    assign carry_out  = en && !dir && (q == MAX);
    assign borrow_out = en &&  dir && (q == '0);

    // NOTE: non-blocking assignment: every cell samples its enable from the
    // pre-edge digit values, so all digits update together on the tick edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= (ld_val > MAX) ? MAX : ld_val;
        end else if (en) begin
            if (dir) q <= (q == '0) ? MAX : q - 4'd1;
            else     q <= (q == MAX) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_mux.sv
// Module: stopwatch_mux
// Stopwatch / countdown timer counting minutes:seconds.tenths in BCD, with a
// tick prescaler, start/stop, clear, preset load, lap freeze, countdown expiry,
// overflow saturation and a time-multiplexed digit output.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   start       pulse: toggle run/stop
//   clear       pulse: digits to 0, stop, release lap, clear flags
//   load        pulse: copy preset into digits while stopped
//   lap         pulse: toggle display freeze
//   down        1 = countdown, sampled when a start is accepted
//   preset      BCD preset, tenths in [3:0]
//   out, sel    displayed digit and its binary position (0 = tenths)
//   running     counter active
//   done        countdown reached zero (sticky)
//   ovf         count-up hit maximum (sticky)
module stopwatch_mux
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 1_000_000,
    parameter int SCAN_DIV   = 10_000,
    parameter int MIN_DIGITS = 1,
    parameter int SEL_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          clear,
    input  logic                          load,
    input  logic                          lap,
    input  logic                          down,
    input  logic [4*(3+MIN_DIGITS)-1:0]   preset,
    output logic [3:0]                    out,
    output logic [SEL_W-1:0]              sel,
    output logic                          running,
    output logic                          done,
    output logic                          ovf
);

    localparam int NDIG   = 3 + MIN_DIGITS;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    bcd_t              digits [NDIG];
    bcd_t              snap   [NDIG];
    logic [NDIG:0]     chain;
    logic [TICK_W-1:0] tick_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [SEL_W-1:0]  idx;
    logic              mode_down;
    logic              lap_on;
    logic              at_max;
    logic              all_zero;
    logic              at_one;
    logic              wrap;
    logic              load_ok;
    logic              start_blocked;
    logic              step;
    logic              carry_unused;

    // Value classification used by start gating and terminal conditions.
    always_comb begin
        at_max   = 1'b1;
        all_zero = 1'b1;
        at_one   = (digits[0] == 4'd1);
        for (int i = 0; i < NDIG; i++) begin
            if (digits[i] != digit_max(i)) at_max   = 1'b0;
            if (digits[i] != '0)           all_zero = 1'b0;
            if (i > 0 && digits[i] != '0)  at_one   = 1'b0;
        end
    end

    assign wrap          = running && (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign load_ok       = load && !clear && !running;
    assign start_blocked = down ? all_zero : at_max;
    // A tick steps the digits unless a command owns this edge or an up-count
    // is already saturated (digits hold, ovf is raised instead).
    assign step          = wrap && !clear && !start && !(!mode_down && at_max);

    // Control: run state, mode, sticky flags and tick prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running   <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            mode_down <= 1'b0;
            tick_cnt  <= '0;
        end else if (clear) begin
            running <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else if (start && !load_ok) begin
            if (running) begin
                running <= 1'b0;
            end else if (!start_blocked) begin
                running   <= 1'b1;
                mode_down <= down;
                tick_cnt  <= '0;
                done      <= 1'b0;
                ovf       <= 1'b0;
            end
        end else if (running) begin
            if (wrap) begin
                tick_cnt <= '0;
                if (!mode_down && at_max) begin
                    ovf     <= 1'b1;
                    running <= 1'b0;
                end else if (mode_down && at_one) begin
                    done    <= 1'b1;
                    running <= 1'b0;
                end
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Digit chain: each cell's carry/borrow enables the next position.
    assign chain[0] = step;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        logic c_o;
        logic b_o;
        bcd_digit_cell #(.MAX(digit_max(g))) u_cell (
            .clk        (clk),
            .rst        (rst),
            .en         (chain[g]),
            .dir        (mode_down),
            .ld         (load_ok),
            .ld_val     (preset[4*g +: 4]),
            .clr        (clear),
            .q          (digits[g]),
            .carry_out  (c_o),
            .borrow_out (b_o)
        );
        assign chain[g+1] = c_o | b_o;
    end

    // Carry out of the top digit cannot occur: saturation suppresses it.
    assign carry_unused = chain[NDIG];

    // Lap freeze: first pulse captures the live digits, second releases.
    // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset
    // along with everything else and the display is defined after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_on <= 1'b0;
            snap   <= '{default: '0};
        end else if (clear) begin
            lap_on <= 1'b0;
        end else if (lap) begin
            if (!lap_on) snap <= digits;
            lap_on <= !lap_on;
        end
    end

    // Scan prescaler and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == SEL_W'(NDIG - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // NOTE: out gets a default before the loop so no latch is inferred for
    // index values that select no digit.
    always_comb begin
        out = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == SEL_W'(i)) out = lap_on ? snap[i] : digits[i];
        end
    end

    assign sel = idx;

endmodule

// File: tb/tb_stopwatch_mux.sv
// Testbench for stopwatch_mux with TICK_DIV=4, SCAN_DIV=2, MIN_DIGITS=1.
// A time-in-tenths model predicts every output each cycle; directed steps
// pin the model and the DUT against hand-computed values.
module tb_stopwatch_mux;

    localparam int TICK_DIV   = 4;
    localparam int SCAN_DIV   = 2;
    localparam int MIN_DIGITS = 1;
    localparam int SEL_W      = 3;
    localparam int NDIG       = 3 + MIN_DIGITS;
    localparam int MAXV       = 5999;   // 9:59.9 in tenths

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear, load, lap, down;
    logic [15:0] preset;
    logic [3:0]  out;
    logic [SEL_W-1:0] sel;
    logic        running, done, ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: time as an integer number of tenths.
    int m_val = 0, m_snap = 0, m_el = 0, m_cyc = 0;
    bit m_run = 0, m_mdown = 0, m_done = 0, m_ovf = 0, m_lap = 0;

    stopwatch_mux #(
        .TICK_DIV   (TICK_DIV),
        .SCAN_DIV   (SCAN_DIV),
        .MIN_DIGITS (MIN_DIGITS),
        .SEL_W      (SEL_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .clear   (clear),
        .load    (load),
        .lap     (lap),
        .down    (down),
        .preset  (preset),
        .out     (out),
        .sel     (sel),
        .running (running),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digit_of(input int v, input int i);
        case (i)
            0:       return v % 10;
            1:       return (v / 10) % 10;
            2:       return ((v / 10) % 60) / 10;
            default: return v / 600;
        endcase
    endfunction

    function automatic int sat_value(input logic [15:0] p);
        int v;
        int d;
        int lim;
        int w [4];
        w[0] = 1; w[1] = 10; w[2] = 100; w[3] = 600;
        v = 0;
        for (int i = 0; i < 4; i++) begin
            d   = int'(p[4*i +: 4]);
            lim = (i == 2) ? 5 : 9;
            if (d > lim) d = lim;
            v += d * w[i];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_val = 0; m_snap = 0; m_el = 0; m_cyc = 0;
        m_run = 0; m_mdown = 0; m_done = 0; m_ovf = 0; m_lap = 0;
    endtask

    // Advance the model by the clock edge just passed; inputs still hold
    // the values that edge saw.
    task automatic model_step();
        m_cyc++;
        if (clear) m_lap = 0;
        else if (lap) begin
            if (!m_lap) m_snap = m_val;
            m_lap = !m_lap;
        end
        if (clear) begin
            m_val = 0; m_run = 0; m_done = 0; m_ovf = 0;
        end else if (load && !m_run) begin
            m_val = sat_value(preset);
        end else if (start) begin
            if (m_run) m_run = 0;
            else if (down ? (m_val != 0) : (m_val != MAXV)) begin
                m_run = 1; m_mdown = down; m_el = 0; m_done = 0; m_ovf = 0;
            end
        end else if (m_run) begin
            m_el++;
            if (m_el == TICK_DIV) begin
                m_el = 0;
                if (!m_mdown) begin
                    if (m_val == MAXV) begin m_ovf = 1; m_run = 0; end
                    else m_val++;
                end else begin
                    m_val--;
                    if (m_val == 0) begin m_done = 1; m_run = 0; end
                end
            end
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int e_idx;
        if (!rst) model_reset();
        else      model_step();
        e_idx = (m_cyc / SCAN_DIV) % NDIG;
        check("cyc_sel", int'(sel), e_idx);
        check("cyc_out", int'(out), digit_of(m_lap ? m_snap : m_val, e_idx));
        check("cyc_running", int'(running), int'(m_run));
        check("cyc_done", int'(done), int'(m_done));
        check("cyc_ovf", int'(ovf), int'(m_ovf));
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // One-cycle command pulse; the command edge is the next posedge.
    task automatic cmd(input bit s, input bit l, input bit c, input bit lp);
        start = s; load = l; clear = c; lap = lp;
        cycles(1);
        start = 0; load = 0; clear = 0; lap = 0;
    endtask

    task automatic set_preset(input int mn, input int st, input int su, input int t);
        preset = {4'(mn), 4'(st), 4'(su), 4'(t)};
    endtask

    // Collect one full scan of the display and return it as tenths.
    task automatic read_display(output int v);
        int d [NDIG];
        bit got [NDIG];
        int n_got;
        int s;
        n_got = 0;
        for (int i = 0; i < NDIG; i++) begin d[i] = 0; got[i] = 0; end
        for (int c = 0; c < 2 * NDIG * SCAN_DIV + 2 && n_got < NDIG; c++) begin
            @(negedge clk);
            #1;
            s = int'(sel);
            if (s < NDIG && !got[s]) begin
                got[s] = 1;
                d[s]   = int'(out);
                n_got++;
            end
        end
        if (n_got != NDIG) begin
            n_checks++;
            n_errors++;
            $display("FAIL read_display: saw %0d digits, expected %0d", n_got, NDIG);
        end
        v = d[0] + 10 * d[1] + 100 * d[2] + 600 * d[3];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        int v;
        int exp_sel [8];
        exp_sel = '{0, 1, 1, 2, 2, 3, 3, 0};

        start = 0; clear = 0; load = 0; lap = 0; down = 0; preset = '0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // 1. Reset and scan
        cycles(3);
        check("rst_out", int'(out), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_running", int'(running), 0);
        rst = 1'b1;
        for (int n = 0; n < 8; n++) begin
            cycles(1);
            check("scan_sel", int'(sel), exp_sel[n]);
        end

        // 2. Up-count with carries
        cmd(1, 0, 0, 0);
        cycles(39);
        check("up_model_t39", m_val, 9);
        cycles(1);
        check("up_model_t40", m_val, 10);
        cycles(360);
        check("up_model_t400", m_val, 100);
        cmd(1, 0, 0, 0);
        check("up_stopped", int'(running), 0);
        read_display(v);
        check("up_display", v, 100);

        // 3. Wrap and saturation
        set_preset(0, 5, 9, 9);
        cmd(0, 1, 0, 0);
        check("load_model", m_val, 599);
        cmd(1, 0, 0, 0);
        cycles(4);
        check("wrap_model", m_val, 600);
        cmd(1, 0, 0, 0);
        read_display(v);
        check("wrap_display", v, 600);

        set_preset(9, 5, 9, 8);
        cmd(0, 1, 0, 0);
        cmd(1, 0, 0, 0);
        cycles(8);
        check("sat_ovf", int'(ovf), 1);
        check("sat_running", int'(running), 0);
        read_display(v);
        check("sat_display", v, 5999);
        cmd(1, 0, 0, 0);
        check("sat_restart_running", int'(running), 0);
        check("sat_restart_ovf", int'(ovf), 1);
        set_preset(15, 7, 12, 10);
        cmd(0, 1, 0, 0);
        read_display(v);
        check("load_saturate", v, 5999);

        // 4. Countdown expiry
        down = 1;
        set_preset(0, 0, 1, 2);
        cmd(0, 1, 0, 0);
        cmd(1, 0, 0, 0);
        check("dn_ovf_cleared", int'(ovf), 0);
        cycles(47);
        check("dn_running_t47", int'(running), 1);
        check("dn_done_t47", int'(done), 0);
        cycles(1);
        check("dn_done_t48", int'(done), 1);
        check("dn_running_t48", int'(running), 0);
        read_display(v);
        check("dn_display", v, 0);
        cmd(1, 0, 0, 0);
        check("dn_restart_running", int'(running), 0);
        check("dn_restart_done", int'(done), 1);
        set_preset(0, 0, 0, 3);
        cmd(0, 1, 0, 0);
        cmd(1, 0, 0, 0);
        check("dn_done_cleared", int'(done), 0);
        check("dn_rerun", int'(running), 1);
        cmd(1, 0, 0, 0);

        // 5. Lap and priority
        down = 0;
        cmd(0, 0, 1, 0);
        cmd(1, 0, 0, 0);
        cycles(21);
        cmd(0, 0, 0, 1);
        check("lap_model_snap", m_snap, 5);
        cycles(20);
        check("lap_model_live", m_val, 10);
        cmd(1, 0, 0, 0);
        read_display(v);
        check("lap_frozen", v, 5);
        cmd(0, 0, 0, 1);
        read_display(v);
        check("lap_released", v, 10);
        cmd(1, 0, 0, 0);
        down = 1;
        cycles(8);
        cmd(1, 0, 0, 0);
        down = 0;
        read_display(v);
        check("mode_unchanged", v, 12);
        cmd(1, 0, 1, 0);
        check("clr_start_running", int'(running), 0);
        read_display(v);
        check("clr_start_display", v, 0);

        // 6. Asynchronous reset mid-run
        cmd(1, 0, 0, 0);
        cycles(148);
        check("arst_model", m_val, 37);
        check("arst_pre_running", int'(running), 1);
        rst = 1'b0;
        #1;
        check("arst_out", int'(out), 0);
        check("arst_sel", int'(sel), 0);
        check("arst_running", int'(running), 0);
        check("arst_done", int'(done), 0);
        check("arst_ovf", int'(ovf), 0);
        cycles(2);
        rst = 1'b1;
        cycles(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_mux.md
# stopwatch_mux

Parametrised stopwatch/countdown timer: counts decimal minutes:seconds.tenths, driven by an internal tick prescaler, and time-multiplexes the digits onto one 4-bit digit bus plus a binary digit select for the seven-segment driver. It adds the following to the fixed-function time counter:
- start/stop, clear and preset load;
- lap freeze;
- countdown mode with expiry;
- overflow saturation;
- configurable tick, scan rate and minute width.

It sits between the board clock and the segment decoder.

## Interface
- `TICK_DIV`, 1_000_000, clocks per tenth-second tick (≥2)
- `SCAN_DIV`, 10_000, clocks per display digit step (≥1)
- `MIN_DIGITS`, 1, minute digits, 1 or 2; `NDIG = 3 + MIN_DIGITS`
- `SEL_W`, 3, width of `sel` (2^SEL_W ≥ NDIG)

Ports:
- `clk` in 1: single clock.
- `rst` in 1: **asynchronous, active-low** reset.
- `start` in 1: one-cycle pulse; toggles run/stop.
- `clear` in 1: one-cycle pulse; digits to 0, stop, release lap, clear flags.
- `load` in 1: one-cycle pulse; copy `preset` into digits, accepted only while stopped.
- `lap` in 1: one-cycle pulse; toggles display freeze.
- `down` in 1: 1 = countdown. Sampled only while stopped.
- `preset` in 4*NDIG: BCD digits, tenths in [3:0].
- `out` out 4: BCD digit currently displayed.
- `sel` out SEL_W: binary index of displayed digit; 0 = tenths, 1 = seconds units, 2 = seconds tens, 3+ = minutes.
- `running` out 1: counter active.
- `done` out 1: countdown reached zero; sticky.
- `ovf` out 1: count-up hit maximum; sticky.

## Operation
**Reset (rst=0).** All of the following clear immediately, without a clock edge:
- digits, snapshot, prescalers, scan index, mode register;
- `running`, `done`, `ovf`, lap state.

Consequently `out=0` and `sel=0`.

**Digit ranges.**
- Tenths: 0–9.
- Seconds units: 0–9.
- Seconds tens: 0–5.
- Each minute digit: 0–9.
- Maximum value: 9:59.9 for `MIN_DIGITS=1`, 99:59.9 for `MIN_DIGITS=2`.

**Command priority (same cycle).** `clear` > `load` > `start`. `lap` is independent, except that `clear` forces lap off.

**`start`.**
- While stopped: sets `running`, latches `down`, zeroes the tick prescaler.
- While running: clears `running`. The prescaler holds its value.
- Ignored, with `running` staying 0, when:
  - countdown mode is selected and all digits are 0; or
  - count-up mode is selected and the digits are at maximum.
- A start that is accepted clears `done` and `ovf`.

**`load`.**
- Ignored while running.
- Preset digits above their range are stored saturated to the range maximum.

**Tick.**
- The prescaler counts 0..TICK_DIV-1 only while running.
- A tick occurs on the edge where the prescaler wraps.

**Count-up step.**
- Tenths increments.
- A digit at its maximum returns to 0 and carries into the next digit.

**Countdown step.**
- Tenths decrements.
- A digit at 0 becomes its maximum and borrows from the next digit.

**Terminal conditions.**
- Count-up, tick arriving at maximum: digits hold, `ovf`=1 and `running`=0 on that edge.
- Countdown, tick that produces all-zero: `done`=1 and `running`=0 on that same edge.

**Lap.**
- First pulse: copy live digits into a snapshot and display the snapshot.
- Counting continues underneath.
- Second pulse: display live digits again.

**Scan.**
- The scan prescaler runs continuously.
- Every SCAN_DIV clocks the index advances 0..NDIG-1, then wraps to 0.
- `out` and `sel` are combinational from the index and the display source (live or snapshot).

## Timing
- Start accepted at edge k: first increment at edge k+TICK_DIV.
- Digit updates are registered. All digits change on the tick edge together, with no intermediate ripple state.
- `running`, `done` and `ovf` are registered. They change on the same edge as the digits that cause them.
- `out`/`sel` follow the index with zero cycles of latency.
- The index changes every SCAN_DIV edges. With SCAN_DIV=1 it changes every edge.
- Reset asserted mid-operation: outputs go to their reset values asynchronously.
- Reset release: operation resumes on the first edge after release, without glitch.

## Structure
- Package `stopwatch_pkg`:
  - `bcd_t` (logic [3:0]);
  - constants `DIG_MAX_9=9`, `DIG_MAX_5=5`;
  - a function returning the maximum for a given digit index.
- Sub-module `bcd_digit_cell`:
  - parameter: `MAX`;
  - inputs: `en`, `dir`, `ld`, `ld_val`, `clr`;
  - outputs: `q`, `carry_out` (at MAX and stepping up), `borrow_out` (at 0 and stepping down).
  - Instantiated NDIG times in a generate chain.
- Top level: prescalers, control, lap snapshot, scan mux.

## Test plan
Bench parameters: TICK_DIV=4, SCAN_DIV=2, MIN_DIGITS=1.

1. **Reset and scan.** Reset low for 3 clocks, then release → `out=0`, `sel=0`, `running=0`. `sel` then steps 0,1,2,3,0 every 2 clocks.
2. **Up-count with carries.** Start pulse, then 400 clocks → 0:10.0. The tenths 9→0 carry into seconds happens on tick 10, i.e. 40 clocks after start.
3. **Wrap and saturation.**
   - Load 0:59.9, start, one tick → 1:00.0.
   - Load 9:59.8, start, two ticks → 9:59.9 with `ovf=1` and `running=0`.
   - A further start is ignored.
4. **Countdown expiry.**
   - `down=1`, load 0:01.2, start. After 12 ticks → 0:00.0, with `done=1` and `running=0` on that edge.
   - A further start is ignored.
   - Load 0:00.3, then start → `done` clears.
5. **Lap and priority.**
   - Lap at 0:00.5: the tenths digit stays 5 while the live count advances.
   - Second lap: display shows the live value.
   - `clear`+`start` in the same cycle → digits 0, `running=0`.
   - Start while running with `down` toggled: mode unchanged.
6. **Asynchronous reset mid-run.** Pull `rst` low between edges at 0:03.7 → all outputs become 0 before the next edge.
